// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
// data_memory_responder: services one core load/store at a time against a
// byte-wide RAM or the LED register.            Revision 1.0
// ============================================================================
module data_memory_responder #(
  parameter logic [31:0] MEMORY_SIZE = 32'h1000,
  parameter logic [31:0] LED_ADDRESS = 32'h0000_2000
) (
  input  logic        clk48,
  input  logic        reset_n,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic [31:0] request_address,
  input  logic [2:0]  request_write_sections,
  input  logic [31:0] request_write_value,
  output logic        response_valid,
  input  logic        response_ready,
  output logic [31:0] response_value,
  output logic        response_error,
  output logic        led_on
);

  localparam int ADDR_W = $clog2(MEMORY_SIZE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t              state;
  logic [2:0]          index;
  logic [ADDR_W-1:0]   base;
  logic [2:0]          sections;
  logic [31:0]         wvalue;
  logic                is_err;

  logic [7:0]          ram [MEMORY_SIZE-1:0];
  logic [7:0]          ram_q;
  logic [ADDR_W-1:0]   ram_addr;
  logic [7:0]          ram_wdata;
  logic                lane_en;
  logic                ram_we;
  logic                req_is_led;
  logic                req_in_ram;

  assign req_is_led = (request_address == LED_ADDRESS);
  assign req_in_ram = (request_address <= (MEMORY_SIZE - 32'd4));

  assign ram_addr  = base + ADDR_W'(index);
  assign ram_wdata = wvalue[{index[1:0], 3'b000} +: 8];

  // Lane 2 covers both upper bytes of the word.
  always_comb begin
    lane_en = 1'b0;
    case (index[1:0])
      2'd0:    lane_en = sections[0];
      2'd1:    lane_en = sections[1];
      default: lane_en = sections[2];
    endcase
  end

  assign ram_we = (state == S_ACCESS) && !index[2] && lane_en;

  always_ff @(posedge clk48) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
    ram_q <= ram[ram_addr];
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      index          <= 3'd0;
      base           <= '0;
      sections       <= 3'd0;
      wvalue         <= 32'd0;
      is_err         <= 1'b0;
      request_ready  <= 1'b0;
      response_valid <= 1'b0;
      response_value <= 32'd0;
      response_error <= 1'b0;
      led_on         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (request_valid && request_ready) begin
            request_ready  <= 1'b0;
            base           <= request_address[ADDR_W-1:0];
            sections       <= request_write_sections;
            wvalue         <= request_write_value;
            response_value <= 32'd0;
            index          <= 3'd0;
            is_err         <= !req_is_led && !req_in_ram;
            state          <= (req_is_led || !req_in_ram) ? S_RESPOND : S_ACCESS;
          end else begin
            request_ready <= 1'b1;
          end
        end

        S_ACCESS: begin
          index <= index + 3'd1;
          // RAM output lags the address by one cycle, so byte n lands at index n+1.
          if (sections == 3'b000) begin
            case (index)
              3'd1:    response_value[7:0]   <= ram_q;
              3'd2:    response_value[15:8]  <= ram_q;
              3'd3:    response_value[23:16] <= ram_q;
              3'd4:    response_value[31:24] <= ram_q;
              default: ;
            endcase
          end
          if (index == 3'd4) begin
            response_valid <= 1'b1;
            state          <= S_RESPOND;
          end
        end

        S_RESPOND: begin
          if (!response_valid) begin
            // LED and error requests resolve here, one cycle after accept.
            if (is_err) begin
              response_error <= 1'b1;
            end else if (sections != 3'b000) begin
              led_on <= (wvalue != 32'd0);
            end else begin
              response_value <= {31'd0, led_on};
            end
            response_valid <= 1'b1;
          end else if (response_ready) begin
            response_valid <= 1'b0;
            response_error <= 1'b0;
            request_ready  <= 1'b1;
            state          <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// Scoreboard bench for data_memory_responder: a byte-array model predicts each
// response when the request is accepted; a monitor compares when it appears.
module tb_data_memory_responder;

  localparam logic [31:0] MS  = 32'h1000;
  localparam logic [31:0] LED = 32'h0000_2000;

  logic        clk48 = 1'b0;
  logic        reset_n;
  logic        request_valid;
  logic        request_ready;
  logic [31:0] request_address;
  logic [2:0]  request_write_sections;
  logic [31:0] request_write_value;
  logic        response_valid;
  logic        response_ready;
  logic [31:0] response_value;
  logic        response_error;
  logic        led_on;

  data_memory_responder #(
    .MEMORY_SIZE (MS),
    .LED_ADDRESS (LED)
  ) dut (
    .clk48                  (clk48),
    .reset_n                (reset_n),
    .request_valid          (request_valid),
    .request_ready          (request_ready),
    .request_address        (request_address),
    .request_write_sections (request_write_sections),
    .request_write_value    (request_write_value),
    .response_valid         (response_valid),
    .response_ready         (response_ready),
    .response_value         (response_value),
    .response_error         (response_error),
    .led_on                 (led_on)
  );

  always #5 clk48 = ~clk48;

  int cyc = 0;
  always @(posedge clk48) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] value;
    logic        error;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  mdl [0:4095];
  logic        led_m;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          reported = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input bit upd);
    exp_t e;
    @(negedge clk48);
    for (int i = 0; i < 200 && !request_ready; i++) @(negedge clk48);
    if (!request_ready) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    request_address        = a;
    request_write_sections = s;
    request_write_value    = d;
    request_valid          = 1'b1;
    @(posedge clk48);
    #1;
    request_valid = 1'b0;
    e.acc   = cyc;
    e.error = 1'b0;
    e.value = 32'd0;
    if (a == LED) begin
      e.lat = 1;
      if (s != 3'b000) begin
        if (upd) led_m = (d != 32'd0);
      end else begin
        e.value = {31'd0, led_m};
      end
    end else if (a <= MS - 32'd4) begin
      e.lat = 5;
      if (s != 3'b000) begin
        if (upd) begin
          if (s[0]) mdl[a]   = d[7:0];
          if (s[1]) mdl[a+1] = d[15:8];
          if (s[2]) begin
            mdl[a+2] = d[23:16];
            mdl[a+3] = d[31:24];
          end
        end
      end else begin
        e.value = model_read(a);
      end
    end else begin
      e.lat   = 1;
      e.error = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 100 && (sb.size() != 0 || response_valid); i++) @(negedge clk48);
    if (sb.size() != 0 || response_valid) check("drain_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clk48) begin
    if (!reset_n) begin
      reported = 1'b0;
    end else if (response_valid && !reported) begin
      reported = 1'b1;
      if (sb.size() == 0) begin
        check("unexpected_response", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("resp_value", response_value, mon_e.value);
        check("resp_error", {31'd0, response_error}, {31'd0, mon_e.error});
        check("resp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end else if (!response_valid) begin
      reported = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, d, hold;
    logic [2:0]  s;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
    led_m                  = 1'b0;
    reset_n                = 1'b0;
    request_valid          = 1'b0;
    request_address        = 32'd0;
    request_write_sections = 3'd0;
    request_write_value    = 32'd0;
    response_ready         = 1'b1;

    repeat (3) @(negedge clk48);
    check("rst_req_ready", {31'd0, request_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, response_valid}, 32'd0);
    check("rst_resp_value", response_value, 32'd0);
    check("rst_led", {31'd0, led_on}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_req_ready_low", {31'd0, request_ready}, 32'd0);
    @(posedge clk48);
    #1;
    check("rel_req_ready_high", {31'd0, request_ready}, 32'd1);

    // full word
    issue(32'h10, 3'b111, 32'hDEADBEEF, 1'b1);
    issue(32'h10, 3'b000, 32'd0, 1'b1);
    // partial and unaligned
    issue(32'h20, 3'b111, 32'h11223344, 1'b1);
    issue(32'h20, 3'b001, 32'hAABBCCDD, 1'b1);
    issue(32'h20, 3'b000, 32'd0, 1'b1);
    issue(32'h21, 3'b000, 32'd0, 1'b1);
    wait_drain();
    check("partial_model", model_read(32'h20), 32'h112233DD);

    // LED set, visible from E1
    issue(LED, 3'b111, 32'd5, 1'b1);
    check("led_at_e0", {31'd0, led_on}, 32'd0);
    @(posedge clk48);
    #1;
    check("led_at_e1", {31'd0, led_on}, 32'd1);
    issue(LED, 3'b000, 32'd0, 1'b1);
    issue(LED, 3'b111, 32'd0, 1'b1);
    wait_drain();
    check("led_cleared", {31'd0, led_on}, 32'd0);

    // bounds
    issue(MS - 32'd4, 3'b111, 32'h01020304, 1'b1);
    issue(MS - 32'd4, 3'b000, 32'd0, 1'b1);
    issue(MS - 32'd3, 3'b000, 32'd0, 1'b1);
    issue(32'hFFFF_FFFF, 3'b000, 32'd0, 1'b1);
    issue(MS - 32'd3, 3'b111, 32'hFFFF_FFFF, 1'b1);
    issue(MS - 32'd4, 3'b000, 32'd0, 1'b1);

    // mixed lanes at arbitrary alignment
    for (int k = 0; k < 8; k++) begin
      a = 32'($urandom_range(0, 127));
      s = 3'($urandom_range(0, 7));
      d = $urandom();
      issue(a, s, d, 1'b1);
      issue(a, 3'b000, 32'd0, 1'b1);
    end

    // back-pressure
    wait_drain();
    response_ready = 1'b0;
    hold = model_read(32'h10);
    issue(32'h10, 3'b000, 32'd0, 1'b1);
    for (int i = 0; i < 20 && !response_valid; i++) @(negedge clk48);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk48);
      check("bp_valid", {31'd0, response_valid}, 32'd1);
      check("bp_value", response_value, hold);
      check("bp_req_ready", {31'd0, request_ready}, 32'd0);
    end
    response_ready = 1'b1;
    @(posedge clk48);
    #1;
    check("bp_release_valid", {31'd0, response_valid}, 32'd0);
    check("bp_release_ready", {31'd0, request_ready}, 32'd1);

    // reset in the middle of a RAM write
    issue(LED, 3'b111, 32'd1, 1'b1);
    issue(32'h40, 3'b111, 32'hCAFEBABE, 1'b1);
    wait_drain();
    issue(32'h40, 3'b111, 32'h11111111, 1'b0);
    @(posedge clk48);
    @(posedge clk48);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, request_ready}, 32'd0);
    check("mid_rst_resp_valid", {31'd0, response_valid}, 32'd0);
    check("mid_rst_resp_value", response_value, 32'd0);
    check("mid_rst_resp_error", {31'd0, response_error}, 32'd0);
    check("mid_rst_led", {31'd0, led_on}, 32'd0);
    sb.delete();
    led_m     = 1'b0;
    mdl[32'h40] = 8'h11;
    mdl[32'h41] = 8'h11;
    @(negedge clk48);
    reset_n = 1'b1;
    #1;
    check("mid_rel_ready_low", {31'd0, request_ready}, 32'd0);
    @(posedge clk48);
    #1;
    check("mid_rel_ready_high", {31'd0, request_ready}, 32'd1);
    check("mid_rel_led", {31'd0, led_on}, 32'd0);
    issue(32'h40, 3'b000, 32'd0, 1'b1);
    wait_drain();
    check("partial_reset_model", model_read(32'h40), 32'hCAFE1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_memory_responder.md
# data_memory_responder

Responder end of the core's data-memory interface: accepts one load/store request at a time from `core`, services it against a byte-wide single-port RAM or the LED register, and returns a response. This is the proper memory-side counterpart to the core's `memory_address` / `memory_value` / `memory_write_sections` outputs. It sits in `top` between `core` and the board LED and replaces the ad-hoc "any write sets the LED" logic.

## Interface

- `MEMORY_SIZE`, default `32'h1000`: RAM size in bytes; a power of two, at least 4.
- `LED_ADDRESS`, default `32'h0000_2000`: byte address of the LED register. It lies outside the RAM range.
- `clk48` in 1: the single clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `request_valid` in 1: the core presents a request.
- `request_ready` out 1: the block can accept a request.
- `request_address` in 32: byte address; any alignment is allowed.
- `request_write_sections` in 3: byte-lane write enables, same encoding as the core.
  - bit0 writes byte 0 (`[7:0]`).
  - bit1 writes byte 1 (`[15:8]`).
  - bit2 writes bytes 2 and 3 (`[31:16]`).
  - `3'b000` means a read.
- `request_write_value` in 32: store data, little-endian.
- `response_valid` out 1: the response is present.
- `response_ready` in 1: the core consumes the response.
- `response_value` out 32: load data. It is 0 for writes and for errors.
- `response_error` out 1: the address was out of range.
- `led_on` out 1: LED register; `top` drives the active-low RGB pins with `~led_on`.

## Operation

- **Storage.** `reg [7:0] ram[MEMORY_SIZE-1:0]`, single port, one byte per cycle, synchronous read (data valid the cycle after the address is issued). Contents are not reset and are zero at configuration.
- **States.** IDLE → ACCESS | RESPOND → IDLE.
- **IDLE.**
  - `request_ready` = 1.
  - On `request_valid && request_ready`, latch the address, sections and value, then drop `request_ready`.
  - Address decode on the latched address:
    - Address == `LED_ADDRESS`: LED access; go to RESPOND.
    - Address <= `MEMORY_SIZE - 4` (32-bit unsigned compare, so there is no wrap): RAM access; go to ACCESS with `index` = 0.
    - Anything else: error. No side effects, `response_error` = 1, `response_value` = 0; go to RESPOND.
- **LED access.**
  - Write (sections != 0): `led_on <= (request_write_value != 0)`, `response_value` = 0.
  - Read: `response_value = {31'b0, led_on}`.
- **ACCESS.** A 3-bit `index` counts 0..4, one step per cycle.
  - For `index` 0–3: address `ram` at `address + index`. If the lane for that byte is enabled, write byte `index` of the write value.
  - For `index` 1–4: for reads, capture the RAM output into `response_value` byte `index-1`.
  - After `index` = 4: go to RESPOND.
  - The number of steps is fixed, regardless of read or write.
- **Mixed lanes.** Partial writes touch only the enabled bytes; the other bytes of the target word are unchanged.
- **RESPOND.**
  - `response_valid` = 1; `response_value` and `response_error` are stable.
  - On `response_valid && response_ready`, clear `response_valid` and `response_error` and go to IDLE.
  - `response_value` is cleared to 0 on the next accept.
- **Outstanding requests.** Only one request is in flight; there is no pipelining. `request_*` inputs are ignored outside IDLE.

## Timing

- **Reset (reset_n = 0, asynchronous):**
  - State = IDLE.
  - `request_ready` = 0; it rises on the first `clk48` edge after `reset_n` is released.
  - `response_valid` = 0, `response_value` = 0, `response_error` = 0, `led_on` = 0.
- **Reset mid-operation:** the request is abandoned with no response. RAM bytes already written stay written; bytes not yet written are unchanged.
- **Latency.** E0 is the accept edge.
  - LED or error: `response_valid` is high from E1.
  - RAM: `response_valid` is high from E5 (5 ACCESS cycles).
- **Response to next accept.** If `response_ready` is held high, the response handshake completes on the first edge with `response_valid` = 1. `request_ready` is high on the following cycle, so the minimum accept-to-accept spacing is:
  - 3 cycles for LED/error;
  - 7 cycles for RAM.
- **Back-pressure.** `response_ready` held low keeps RESPOND indefinitely with the outputs constant.
- **Valid without ready.** `request_valid` asserted while `request_ready` = 0 has no effect; the core holds its request until it is accepted.

## Test plan

- **Reset.** Assert `reset_n` = 0 mid-ACCESS → all outputs are 0 immediately. After release, `request_ready` = 1 one edge later and `led_on` = 0.
- **Full word.** Write `0xDEADBEEF` to 0x10 with sections `3'b111`, then read 0x10 → `response_value` = `0xDEADBEEF`, `response_error` = 0, `response_valid` 5 cycles after each accept.
- **Partial and unaligned.**
  - Write `0x11223344` to 0x20 (`3'b111`), then write `0xAABBCCDD` to 0x20 with sections `3'b001`, then read 0x20 → `0x112233DD`.
  - Read 0x21 → `0x00112233`, since byte 0x24 is 0 from configuration.
- **LED.**
  - Write 5 to `LED_ADDRESS` → `led_on` = 1 from E1, read returns 1.
  - Write 0 → `led_on` = 0.
- **Bounds.**
  - Read `MEMORY_SIZE-4` → `response_error` = 0.
  - Read `MEMORY_SIZE-3` and `32'hFFFF_FFFF` → `response_error` = 1, `response_value` = 0, latency 1, RAM unchanged.
- **Back-pressure.** Hold `response_ready` = 0 for 10 cycles after a read → `response_valid` and `response_value` are stable and `request_ready` = 0. Releasing `response_ready` completes the handshake and `request_ready` returns one cycle later.
